// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART: register map, STATUS bit layout,
// transmitter/receiver state encodings and the bit-period clamp helper.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam int ST_RX_EMPTY  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_RX_OVR    = 5;
  localparam int ST_FRAME_ERR = 6;
  localparam int ST_TX_OVF    = 7;
  localparam int ST_RX_CNT    = 8;

  localparam int MIN_DIV_DEF = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  function automatic logic [15:0] eff_period(input logic [15:0] div, input logic [15:0] min_div);
    return (div < min_div) ? min_div : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head data; occupancy visible the cycle after a push/pop.
// No backpressure beyond flags: push when full and pop when empty are ignored.
module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdat,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdat  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart.sv
// Wishbone UART slave with 8N1 TX/RX and 16-entry FIFOs; ack one cycle after each access.
// No stall path: writes to a full TX FIFO and frames into a full RX FIFO are dropped and flagged.
module wb_uart
  import uart_pkg::*;
#(
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd1736,
  parameter int          MIN_DIV     = MIN_DIV_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [13:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);
  logic        r_ack, r_irq, r_rx_ovr, r_frame_err, r_tx_ovf;
  logic [15:0] r_dat, r_div;
  logic [1:0]  r_irq_en;
  tx_state_t   r_tx_st;
  rx_state_t   r_rx_st;
  logic        r_txd, r_rx_s1, r_rx_s2, r_rx_prev;
  logic [7:0]  r_tx_sh, r_rx_sh;
  logic [15:0] r_tx_per, r_tx_cnt, r_rx_per, r_rx_cnt;
  logic [2:0]  r_tx_bit, r_rx_bit;

  logic        w_acc, w_wr, w_rd, w_tx_push, w_tx_pop, w_rx_pop, w_rx_push, w_rx_stop_smp;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [7:0]  w_tx_dat, w_rx_dat;
  logic [FIFO_AW:0] w_tx_cnt, w_rx_cnt;
  logic [1:0]  w_adr;
  logic [15:0] w_per, w_status, w_rdata;
  logic        w_unused;

  assign w_unused  = &{1'b0, wb_sel_i, wb_adr_i[13:2], w_tx_cnt};
  assign w_adr     = wb_adr_i[1:0];
  assign w_acc     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd      = w_acc & ~wb_we_i;
  assign w_per     = eff_period(r_div, 16'(MIN_DIV));
  assign w_tx_push = w_wr & (w_adr == REG_DATA);
  assign w_rx_pop  = w_rd & (w_adr == REG_DATA) & ~w_rx_empty;
  assign w_tx_pop  = ~w_tx_empty & ((r_tx_st == TX_IDLE) | ((r_tx_st == TX_STOP) & (r_tx_cnt == '0)));
  assign w_rx_stop_smp = (r_rx_st == RX_STOP) & (r_rx_cnt == '0);
  assign w_rx_push = w_rx_stop_smp & r_rx_s2;

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign uart_txd = r_txd;
  assign irq      = r_irq;

  uart_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
    .i_clk(clk), .i_rst_n(resetn), .i_push(w_tx_push), .i_wdat(wb_dat_i[7:0]), .i_pop(w_tx_pop),
    .o_rdat(w_tx_dat), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_cnt));

  uart_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
    .i_clk(clk), .i_rst_n(resetn), .i_push(w_rx_push), .i_wdat(r_rx_sh), .i_pop(w_rx_pop),
    .o_rdat(w_rx_dat), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_cnt));

  always_comb begin
    w_status = '0;
    w_status[ST_RX_EMPTY]     = w_rx_empty;
    w_status[ST_RX_FULL]      = w_rx_full;
    w_status[ST_TX_EMPTY]     = w_tx_empty;
    w_status[ST_TX_FULL]      = w_tx_full;
    w_status[ST_TX_BUSY]      = (r_tx_st != TX_IDLE);
    w_status[ST_RX_OVR]       = r_rx_ovr;
    w_status[ST_FRAME_ERR]    = r_frame_err;
    w_status[ST_TX_OVF]       = r_tx_ovf;
    w_status[ST_RX_CNT +: 5]  = 5'(w_rx_cnt);
    case (w_adr)
      REG_DATA:   w_rdata = w_rx_empty ? 16'h0000 : {8'h00, w_rx_dat};
      REG_STATUS: w_rdata = w_status;
      REG_DIV:    w_rdata = r_div;
      default:    w_rdata = {14'h0000, r_irq_en};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ack <= 1'b0; r_dat <= '0; r_div <= DEFAULT_DIV; r_irq_en <= '0; r_irq <= 1'b0;
      r_rx_ovr <= 1'b0; r_frame_err <= 1'b0; r_tx_ovf <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_irq <= (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_empty);
      if (w_acc) r_dat <= wb_we_i ? 16'h0000 : w_rdata;
      if (w_wr && w_adr == REG_DIV)    r_div    <= wb_dat_i;
      if (w_wr && w_adr == REG_IRQ_EN) r_irq_en <= wb_dat_i[1:0];
      // Clear before set so an event in the same cycle as a W1C is not lost.
      if (w_wr && w_adr == REG_STATUS) begin
        if (wb_dat_i[ST_RX_OVR])    r_rx_ovr    <= 1'b0;
        if (wb_dat_i[ST_FRAME_ERR]) r_frame_err <= 1'b0;
        if (wb_dat_i[ST_TX_OVF])    r_tx_ovf    <= 1'b0;
      end
      if (w_tx_push && w_tx_full)        r_tx_ovf    <= 1'b1;
      if (w_rx_push && w_rx_full)        r_rx_ovr    <= 1'b1;
      if (w_rx_stop_smp && !r_rx_s2)     r_frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_st <= TX_IDLE; r_txd <= 1'b1; r_tx_sh <= '0; r_tx_per <= '0; r_tx_cnt <= '0; r_tx_bit <= '0;
    end else if (w_tx_pop) begin
      r_tx_st  <= TX_START;
      r_txd    <= 1'b0;
      r_tx_sh  <= w_tx_dat;
      r_tx_per <= w_per;
      r_tx_cnt <= w_per - 16'd1;
    end else begin
      case (r_tx_st)
        TX_IDLE: r_txd <= 1'b1;
        TX_START, TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= r_tx_per - 16'd1;
            if (r_tx_st == TX_DATA && r_tx_bit == 3'd7) begin
              r_tx_st <= TX_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_tx_bit <= (r_tx_st == TX_START) ? 3'd0 : r_tx_bit + 3'd1;
              r_tx_st  <= TX_DATA;
              r_txd    <= r_tx_sh[0];
              r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
            end
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        default: begin
          if (r_tx_cnt == '0) r_tx_st <= TX_IDLE;
          else                r_tx_cnt <= r_tx_cnt - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_st <= RX_IDLE; r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_sh <= '0; r_rx_per <= '0; r_rx_cnt <= '0; r_rx_bit <= '0;
    end else begin
      r_rx_s1   <= uart_rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_st)
        RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
          r_rx_st  <= RX_START;
          r_rx_per <= w_per;
          r_rx_cnt <= (w_per >> 1) - 16'd1;
        end
        RX_START, RX_DATA, RX_STOP: begin
          if (r_rx_cnt == '0) begin
            r_rx_cnt <= r_rx_per - 16'd1;
            if (r_rx_st == RX_START) begin
              r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
              r_rx_bit <= 3'd0;
            end else if (r_rx_st == RX_DATA) begin
              r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
              r_rx_bit <= r_rx_bit + 3'd1;
              if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
            end else r_rx_st <= r_rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        default: if (r_rx_s2) r_rx_st <= RX_IDLE;
      endcase
    end
  end

endmodule
